// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM encoding,
// latched request record and the access legality helpers.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } req_t;

  // funct3[1:0] carries the access size for both signed and unsigned loads.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   is_misaligned = addr_lo[0];
      2'b10:   is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal_f3(input logic we, input logic [2:0] funct3);
    if (we) is_illegal_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    else    is_illegal_f3 = (funct3 inside {3'b011, 3'b110, 3'b111});
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores; purely combinational, no backpressure.
// Store side yields byte enables plus lane-replicated data, load side yields extended data.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o    = 4'b0000;
    wword_o = 32'h0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wword_o = 32'h0;
      end
    endcase
  end

  always_comb begin
    byte_sel = rword_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rword_i[7:0];
      2'd1: byte_sel = rword_i[15:8];
      2'd2: byte_sel = rword_i[23:16];
      2'd3: byte_sel = rword_i[31:24];
      default: byte_sel = rword_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  always_comb begin
    rdata_o = 32'h0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_o = {24'h0, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_o = {16'h0, half_sel};
      F3_W:    rdata_o = rword_i;
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data memory: accepts one load/store, answers WAIT_CYCLES+1 cycles after accept
// with a one-cycle rsp_valid_o pulse; ready is low from accept until back in IDLE.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        stall_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  reg [31:0] mem [0:DEPTH_WORDS-1];

  state_e      state_q;
  logic [2:0]  cnt_q;
  req_t        req_q;
  logic        rsp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  req_t        in_req;
  req_t        cur;
  logic        accept;
  logic        enter_resp;
  logic        acc_err;
  logic [AW-1:0] widx;
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] ld_data;
  logic        unused_addr_hi;

  assign req_ready_o = (state_q == S_IDLE) & ~rst;
  assign accept      = req_valid_i & req_ready_o;

  assign acc_err = is_misaligned(req_funct3_i, req_addr_i[1:0])
                 | is_illegal_f3(req_we_i, req_funct3_i)
                 | ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    in_req        = '0;
    in_req.we     = req_we_i;
    in_req.funct3 = req_funct3_i;
    in_req.addr   = req_addr_i;
    in_req.wdata  = req_wdata_i;
    in_req.err    = acc_err;
  end

  // With zero wait cycles the access completes on the accept edge, before the latch holds it.
  assign cur = (state_q == S_IDLE) ? in_req : req_q;

  assign enter_resp = ((state_q == S_IDLE) & accept & (WAIT_CYCLES == 0))
                    | ((state_q == S_WAIT) & (cnt_q == 3'd0));

  assign widx           = cur.addr[AW+1:2];
  assign rword          = mem[widx];
  assign unused_addr_hi = ^cur.addr[31:AW+2];

  dmem_lane_align u_align (
    .funct3_i  (cur.funct3),
    .addr_lo_i (cur.addr[1:0]),
    .wdata_i   (cur.wdata),
    .rword_i   (rword),
    .be_o      (be),
    .wword_o   (wword),
    .rdata_o   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (enter_resp && cur.we && !cur.err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_q   <= in_req;
            cnt_q   <= 3'(WAIT_CYCLES - 1);
            state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        err_q       <= cur.err;
        rdata_q     <= (cur.err || cur.we) ? 32'h0 : ld_data;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign stall_o     = req_valid_i & ~rsp_valid_q;

  // The requester must keep the request up until the response pulse.
  a_hold_valid: assert property (@(posedge clk) disable iff (rst) (state_q == S_WAIT) |-> req_valid_i);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one WAIT_CYCLES=1 instance for latency, lanes, errors
// and reset; one WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;

  logic        v0, we0;
  logic [2:0]  f30;
  logic [31:0] a0, d0;
  logic        rdy0, rv0, er0, st0;
  logic [31:0] rd0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_funct3_i(req_f3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .stall_o(stall)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(v0), .req_we_i(we0), .req_funct3_i(f30),
    .req_addr_i(a0), .req_wdata_i(d0),
    .req_ready_o(rdy0), .rsp_valid_o(rv0), .rsp_rdata_o(rd0),
    .rsp_err_o(er0), .stall_o(st0)
  );

  // One access on the WAIT_CYCLES=1 instance; lat counts negedges from drive to response,
  // stl counts sampled stall cycles (a stall seen during the response adds 100).
  task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdo, output logic ero,
                        output int lato, output int stlo);
    @(negedge clk);
    req_valid = 1'b1; req_we = w; req_f3 = f; req_addr = a; req_wdata = d;
    #1;
    stlo = stall ? 1 : 0;
    lato = 0;
    while (!rsp_valid && lato < 20) begin
      @(negedge clk);
      lato++;
      if (!rsp_valid) stlo += stall ? 1 : 0;
      else if (stall) stlo += 100;
    end
    rdo = rsp_rdata;
    ero = rsp_err;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", req_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", rsp_rdata); else passed++;
    total++; if (rsp_err !== 1'b0) $display("FAIL rst_err got %b exp 0", rsp_err); else passed++;
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", req_ready); else passed++;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat, stl;
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, stl);
    total++; if (lat !== 2) $display("FAIL sw_latency got %0d exp 2", lat); else passed++;
    total++; if (stl !== 2) $display("FAIL sw_stall got %0d exp 2", stl); else passed++;
    total++; if ({er, rd} !== 33'h0) $display("FAIL sw_rsp got err=%b rdata=%h exp 0/0", er, rd); else passed++;
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
    total++; if (lat !== 2) $display("FAIL lw_latency got %0d exp 2", lat); else passed++;
    total++; if (stl !== 2) $display("FAIL lw_stall got %0d exp 2", stl); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_data got %h exp deadbeef", rd); else passed++;
    total++; if (er !== 1'b0) $display("FAIL lw_err got %b exp 0", er); else passed++;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) $display("FAIL valid_pulse got %b exp 0", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL rdata_hold got %h exp deadbeef", rsp_rdata); else passed++;
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic er; int lat, stl;
    access(1'b1, 3'b000, 32'h13, 32'h12345680, rd, er, lat, stl);
    total++; if (er !== 1'b0) $display("FAIL sb_err got %b exp 0", er); else passed++;
    access(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat, stl);
    total++; if (rd !== 32'hFFFFFF80) $display("FAIL lb got %h exp ffffff80", rd); else passed++;
    access(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat, stl);
    total++; if (rd !== 32'h00000080) $display("FAIL lbu got %h exp 00000080", rd); else passed++;
    access(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat, stl);
    total++; if (rd !== 32'hFFFF80AD) $display("FAIL lh got %h exp ffff80ad", rd); else passed++;
    access(1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat, stl);
    total++; if (rd !== 32'h0000BEEF) $display("FAIL lhu got %h exp 0000beef", rd); else passed++;
    access(1'b1, 3'b001, 32'h12, 32'h1234CAFE, rd, er, lat, stl);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
    total++; if (rd !== 32'hCAFEBEEF) $display("FAIL sh_word got %h exp cafebeef", rd); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, stl;
    access(1'b1, 3'b010, 32'h0, 32'h11223344, rd, er, lat, stl);
    access(1'b0, 3'b010, 32'h11, 32'h0, rd, er, lat, stl);
    total++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL lw_misalign got err=%b rdata=%h exp 1/0", er, rd); else passed++;
    access(1'b1, 3'b001, 32'h03, 32'h5555, rd, er, lat, stl);
    total++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL sh_misalign got err=%b rdata=%h exp 1/0", er, rd); else passed++;
    access(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat, stl);
    total++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL lw_range got err=%b rdata=%h exp 1/0", er, rd); else passed++;
    total++; if (lat !== 2) $display("FAIL err_latency got %0d exp 2", lat); else passed++;
    access(1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF, rd, er, lat, stl);
    total++; if (er !== 1'b1) $display("FAIL sw_range got %b exp 1", er); else passed++;
    access(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat, stl);
    total++; if ({er, rd} !== {1'b0, 32'h11223344}) $display("FAIL word0_intact got err=%b rdata=%h exp 0/11223344", er, rd); else passed++;
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
    total++; if (rd !== 32'hCAFEBEEF) $display("FAIL word4_intact got %h exp cafebeef", rd); else passed++;
  endtask

  task automatic test_illegal_f3();
    logic [31:0] rd; logic er; int lat, stl;
    access(1'b0, 3'b011, 32'h0, 32'h0, rd, er, lat, stl);
    total++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL ld_f3_011 got err=%b rdata=%h exp 1/0", er, rd); else passed++;
    access(1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, rd, er, lat, stl);
    total++; if (er !== 1'b1) $display("FAIL st_f3_100 got %b exp 1", er); else passed++;
    total++; if (dut.mem[0] !== 32'h11223344) $display("FAIL mem0_dump got %h exp 11223344", dut.mem[0]); else passed++;
    access(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat, stl);
    total++; if ({er, rd} !== {1'b0, 32'h11223344}) $display("FAIL f3_no_side got err=%b rdata=%h exp 0/11223344", er, rd); else passed++;
  endtask

  task automatic test_back_to_back();
    logic        tw [4];
    logic [31:0] ta [4];
    logic [31:0] td [4];
    logic [31:0] te [4];
    int idx, last, pulses;
    tw = '{1'b1, 1'b1, 1'b0, 1'b0};
    ta = '{32'h0, 32'h4, 32'h0, 32'h4};
    td = '{32'hA1B2C3D4, 32'h55667788, 32'h0, 32'h0};
    te = '{32'h0, 32'h0, 32'hA1B2C3D4, 32'h55667788};
    idx = 0; last = -1; pulses = 0;
    @(negedge clk);
    v0 = 1'b1; we0 = tw[0]; f30 = 3'b010; a0 = ta[0]; d0 = td[0];
    for (int c = 1; c <= 20 && idx < 4; c++) begin
      @(negedge clk);
      if (rv0) begin
        total++; if (rdy0 !== 1'b0) $display("FAIL b2b_ready_resp%0d got %b exp 0", idx, rdy0); else passed++;
        total++; if (rd0 !== te[idx]) $display("FAIL b2b_rdata%0d got %h exp %h", idx, rd0, te[idx]); else passed++;
        if (last >= 0) begin
          total++; if (c - last !== 2) $display("FAIL b2b_gap%0d got %0d exp 2", idx, c - last); else passed++;
        end
        last = c; pulses++; idx++;
        if (idx < 4) begin
          we0 = tw[idx]; a0 = ta[idx]; d0 = td[idx];
        end else begin
          v0 = 1'b0;
        end
      end
    end
    v0 = 1'b0;
    total++; if (pulses !== 4) $display("FAIL b2b_pulses got %0d exp 4", pulses); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat, stl;
    access(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rd, er, lat, stl);
    access(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, stl);
    total++; if (rd !== 32'hCAFEF00D) $display("FAIL pre_rst_lw got %h exp cafef00d", rd); else passed++;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) $display("FAIL mid_wait_valid got %b exp 0", rsp_valid); else passed++;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    total++; if ({req_ready, rsp_valid, rsp_err, stall} !== 4'b0) $display("FAIL mid_rst_ctl got %b exp 0000", {req_ready, rsp_valid, rsp_err, stall}); else passed++;
    total++; if (rsp_rdata !== 32'h0) $display("FAIL mid_rst_rdata got %h exp 0", rsp_rdata); else passed++;
    repeat (2) @(negedge clk);
    total++; if (dut.mem[8] !== 32'hCAFEF00D) $display("FAIL mid_rst_mem got %h exp cafef00d", dut.mem[8]); else passed++;
    rst = 1'b0;
    access(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, stl);
    total++; if ({er, rd} !== {1'b0, 32'hCAFEF00D}) $display("FAIL post_rst_lw got err=%b rdata=%h exp 0/cafef00d", er, rd); else passed++;
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    v0 = 1'b0; we0 = 1'b0; f30 = 3'b0; a0 = 32'h0; d0 = 32'h0;
    test_reset();
    test_store_load();
    test_byte_half();
    test_errors();
    test_illegal_f3();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
